sisc_fetch: RTL and testbench
=============================

Name: sisc_fetch

Overview:
Parametrised instruction-fetch unit for the next-generation SISC core. It replaces the fixed pc/ir/br trio with a self-sequencing fetch engine. The engine issues requests to an instruction memory with variable latency over a req/ack handshake and buffers fetched words in a prefetch queue of DEPTH entries. Instructions are handed to the control unit over a valid/ready interface, and the unit accepts absolute or PC-relative branch redirects that flush the queue.

Parameters:
ADDR_W, 16, width of PC and instruction-memory address
INSTR_W, 32, instruction word width
DEPTH, 2, prefetch queue entries (power of two, >=2)
RST_ADDR, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  synchronous reset, active-high
imem_req  out  1  fetch request, registered
imem_addr  out  ADDR_W  fetch address, registered, stable while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle; ends the transaction
imem_rdata  in  INSTR_W  fetched word, valid when imem_ack=1
instr_valid  out  1  queue head holds an instruction
instr  out  INSTR_W  head instruction
instr_pc  out  ADDR_W  address of head instruction
instr_ready  in  1  consumer pops head when instr_valid=1
br_take  in  1  redirect request, one-cycle pulse
br_rel  in  1  1: target = instr_pc+1+br_imm; 0: target = br_imm
br_imm  in  ADDR_W  branch offset or absolute target

Behaviour:
- Reset (sampled at clk edge with rst_f=1):
  - imem_req=0, imem_addr=RST_ADDR, fetch_pc=RST_ADDR.
  - Queue empty, so instr_valid=0; instr and instr_pc read 0 (storage cleared).
  - State IDLE.
  - Reset mid-transaction abandons it; an imem_ack arriving afterwards is ignored because state is IDLE.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding whose data must be discarded.
- Issue condition: (count + (state!=IDLE) - pop) < DEPTH. At most one request is outstanding.
- IDLE:
  - If issue condition holds and no br_take: imem_req<=1, imem_addr<=fetch_pc, go to WAIT.
  - First request is visible one cycle after reset release.
- WAIT, imem_ack=1:
  - Push {imem_rdata, imem_addr}; fetch_pc<=imem_addr+1 (wraps 2^ADDR_W-1 -> 0).
  - If space remains, re-issue back-to-back: imem_req stays 1, imem_addr<=imem_addr+1. Otherwise imem_req<=0, go to IDLE.
  - Throughput is one instruction per cycle with imem_ack tied high.
- WAIT, imem_ack=0: hold imem_req and imem_addr unchanged (protocol rule).
- br_take handling:
  - Target is computed in ADDR_W arithmetic, wrapping modulo 2^ADDR_W. br_rel uses the current head's instr_pc and is only legal while instr_valid=1.
  - Same cycle: the queue is flushed (count<=0) and any simultaneous pop or push is suppressed.
  - IDLE: fetch_pc<=target; issue starts the next cycle.
  - WAIT with imem_ack=1: data discarded, fetch_pc<=target, imem_req<=0, go to IDLE.
  - WAIT with imem_ack=0: imem_req and imem_addr held, fetch_pc<=target, go to DROP.
  - DROP with imem_ack=0: latest target overwrites fetch_pc, stay in DROP.
- DROP, imem_ack=1: data discarded, imem_req<=0, go to IDLE.
- Queue rules:
  - Push and pop in the same cycle when full is legal; count is unchanged.
  - Pop when empty is ignored.
  - Push when full cannot occur, because the issue condition prevents it (assertion in bench).
- Output timing: instr_valid, instr and instr_pc come combinationally from queue head registers. A pushed word appears one cycle after its imem_ack.

Decomposition:
- sisc_pkg: fetch state enum (IDLE/WAIT/DROP) and default ADDR_W/INSTR_W constants shared with the future ctrl.
- One sub-module, fetch_fifo: synchronous FIFO of {INSTR_W+ADDR_W} bits with depth DEPTH, push/pop/flush, full/empty/count, and synchronous active-high reset.
- sisc_fetch holds the FSM, fetch_pc and branch-target adder.

Test Plan:
- Reset, then imem_ack tied 1 and instr_ready=1, rdata=addr-tagged -> imem_req rises 1 cycle after reset, instr_pc sequence 0,1,2,3 one per cycle, instr matches tag.
- instr_ready=0, ack 1, DEPTH=2 -> exactly 2 words queued (pc 0,1), imem_req drops, no third request until a pop.
- imem_ack delayed 3 cycles per request -> imem_addr stable throughout; instr_pc 0,1,2 in order with no duplicates.
- br_take with br_rel=0, br_imm=0x0040 while WAIT with no ack, ack 2 cycles later -> that word discarded (state DROP), next request addr 0x0040, queue empty until its data arrives.
- br_rel=1 with head instr_pc=0xFFFE, br_imm=0x0003 -> target 0x0002 (wrap), queue flushed same cycle, instr_valid=0 next cycle.
- rst_f asserted while WAIT, ack arrives the cycle after reset -> ack ignored, imem_req=0, then restart fetch at RST_ADDR.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: fetch sequencing states and default datapath widths.
package sisc_pkg;

    localparam int SISC_ADDR_W  = 16;
    localparam int SISC_INSTR_W = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush; storage is cleared on reset so the
// head reads zero until the first push.
module fetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst_f) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/sisc_fetch.sv
// Self-sequencing instruction fetch: req/ack memory port, prefetch queue, valid/ready
// hand-off to the control unit and absolute/PC-relative branch redirect.
//
// state      | meaning
// FETCH_IDLE | no memory request outstanding
// FETCH_WAIT | request outstanding, returned word goes into the queue
// FETCH_DROP | request outstanding, returned word is discarded (redirected)
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int                ADDR_W   = SISC_ADDR_W,
    parameter int                INSTR_W  = SISC_INSTR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_f,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               br_take,
    input  logic               br_rel,
    input  logic [ADDR_W-1:0]  br_imm
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic                imem_req_nxt;
    logic [ADDR_W-1:0]   imem_addr_nxt;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   fetch_pc_nxt;
    logic [ADDR_W-1:0]   br_target;
    logic [ADDR_W-1:0]   addr_inc;

    logic                q_push;
    logic                q_pop;
    logic                q_full;
    logic                q_empty;
    logic [CNT_W-1:0]    q_count;
    logic [OCC_W-1:0]    occupancy;
    logic                can_issue;

    fetch_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_f (rst_f),
        .push  (q_push),
        .pop   (q_pop),
        .flush (br_take),
        .wdata ({imem_rdata, imem_addr}),
        .rdata ({instr, instr_pc}),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign instr_valid = !q_empty;
    assign q_pop       = instr_ready && instr_valid && !br_take;
    assign q_push      = (state == FETCH_WAIT) && imem_ack && !br_take && (!q_full || q_pop);

    assign addr_inc  = imem_addr + ADDR_W'(1);
    assign br_target = br_rel ? (instr_pc + ADDR_W'(1) + br_imm) : br_imm;

    // The outstanding request counts as an occupied slot so the queue can never overflow.
    assign occupancy = OCC_W'(q_count) + OCC_W'(state != FETCH_IDLE) - OCC_W'(q_pop);
    assign can_issue = (occupancy < OCC_W'(DEPTH));

    always_comb begin
        state_nxt     = state;
        imem_req_nxt  = imem_req;
        imem_addr_nxt = imem_addr;
        fetch_pc_nxt  = fetch_pc;
        case (state)
            FETCH_IDLE: begin
                if (br_take) begin
                    fetch_pc_nxt = br_target;
                end else if (can_issue) begin
                    imem_req_nxt  = 1'b1;
                    imem_addr_nxt = fetch_pc;
                    state_nxt     = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_ack) begin
                    if (br_take) begin
                        fetch_pc_nxt = br_target;
                        imem_req_nxt = 1'b0;
                        state_nxt    = FETCH_IDLE;
                    end else begin
                        fetch_pc_nxt = addr_inc;
                        if (can_issue) begin
                            imem_addr_nxt = addr_inc;
                        end else begin
                            imem_req_nxt = 1'b0;
                            state_nxt    = FETCH_IDLE;
                        end
                    end
                end else if (br_take) begin
                    fetch_pc_nxt = br_target;
                    state_nxt    = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (br_take) begin
                    fetch_pc_nxt = br_target;
                end
                if (imem_ack) begin
                    imem_req_nxt = 1'b0;
                    state_nxt    = FETCH_IDLE;
                end
            end
            default: begin
                imem_req_nxt = 1'b0;
                state_nxt    = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state     <= FETCH_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RST_ADDR;
            fetch_pc  <= RST_ADDR;
        end else begin
            state     <= state_nxt;
            imem_req  <= imem_req_nxt;
            imem_addr <= imem_addr_nxt;
            fetch_pc  <= fetch_pc_nxt;
        end
    end

endmodule

// File: tb/tb_sisc_fetch.sv
// Randomized scoreboard bench for sisc_fetch: the bench plays instruction memory,
// predicts the delivered instruction stream and request addresses, and checks them.
module tb_sisc_fetch;

    localparam int          ADDR_W   = 16;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 2;
    localparam logic [15:0] RST_ADDR = 16'h0000;

    logic               clk;
    logic               rst_f;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic               br_take;
    logic               br_rel;
    logic [ADDR_W-1:0]  br_imm;

    sisc_fetch #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RST_ADDR (RST_ADDR)
    ) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_take     (br_take),
        .br_rel      (br_rel),
        .br_imm      (br_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      exp_q[$];
    entry_t      pend_e;
    bit          pend_v;
    int          checks = 0;
    int          failures = 0;

    logic [15:0] nxt_addr;
    logic [15:0] fl_addr;
    bit          in_flight;
    bit          fl_drop;
    bit          new_req;
    bit          first_chk;
    bit          mon_en;
    int          wait_cnt;
    int          lat_cur;
    int          lat_min, lat_max, ready_pct, br_pct;
    int          pops;
    int          accepted;
    logic [15:0] last_pop_pc;

    function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // One clock of memory-side and consumer-side stimulus plus model update.
    task automatic step(input bit f_br = 1'b0, input bit f_rel = 1'b0, input logic [15:0] f_imm = 16'h0);
        logic        s_req;
        logic [15:0] s_addr;
        logic [15:0] imm;
        logic [15:0] tgt;
        logic [31:0] rd;
        bit          ack, rdy, br, rel, pop_now;
        @(negedge clk);
        if (pend_v) begin
            exp_q.push_back(pend_e);
            pend_v = 1'b0;
        end
        s_req   = imem_req;
        s_addr  = imem_addr;
        new_req = 1'b0;
        if (first_chk) begin
            check_eq("req_after_reset", 32'(s_req), 32'd1);
            first_chk = 1'b0;
        end
        if (in_flight) begin
            check_eq("req_held", 32'(s_req), 32'd1);
            check_eq("addr_stable", 32'(s_addr), 32'(fl_addr));
            if (!s_req) in_flight = 1'b0;
        end else if (s_req) begin
            check_eq("req_addr", 32'(s_addr), 32'(nxt_addr));
            in_flight = 1'b1;
            fl_addr   = s_addr;
            fl_drop   = 1'b0;
            wait_cnt  = 0;
            lat_cur   = int'($urandom_range(lat_max, lat_min));
            new_req   = 1'b1;
        end
        ack = in_flight && (wait_cnt >= lat_cur);
        rdy = int'($urandom_range(99, 0)) < ready_pct;
        br  = f_br || (int'($urandom_range(99, 0)) < br_pct);
        rel = f_br ? f_rel : ($urandom_range(1, 0) == 1);
        if (exp_q.size() == 0) rel = 1'b0;
        imm = f_br ? f_imm : 16'($urandom);
        rd  = $urandom;

        imem_ack    = ack;
        imem_rdata  = rd;
        instr_ready = rdy;
        br_take     = br;
        br_rel      = rel;
        br_imm      = imm;

        pop_now = rdy && (exp_q.size() > 0) && !br;
        if (br) begin
            tgt = rel ? (exp_q[0].pc + 16'd1 + imm) : imm;
            exp_q.delete();
            nxt_addr = tgt;
            if (in_flight) fl_drop = 1'b1;
        end
        if (ack) begin
            if (!fl_drop) begin
                check_eq("no_push_full", 32'((exp_q.size() - int'(pop_now)) < DEPTH), 32'd1);
                pend_e   = '{fl_addr, rd};
                pend_v   = 1'b1;
                nxt_addr = fl_addr + 16'd1;
                accepted++;
            end
            in_flight = 1'b0;
        end else if (in_flight) begin
            wait_cnt++;
        end
    endtask

    task automatic do_reset(input bit late_ack);
        @(negedge clk);
        rst_f       = 1'b1;
        mon_en      = 1'b0;
        imem_ack    = 1'b0;
        br_take     = 1'b0;
        br_rel      = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'(RST_ADDR));
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc", 32'(instr_pc), 32'd0);
        rst_f      = 1'b0;
        imem_ack   = late_ack;
        imem_rdata = $urandom;
        exp_q.delete();
        pend_v    = 1'b0;
        in_flight = 1'b0;
        nxt_addr  = RST_ADDR;
        first_chk = 1'b1;
        mon_en    = 1'b1;
    endtask

    // Monitor: compares every delivered instruction against the scoreboard.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && !rst_f && !br_take) begin
                check_eq("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
                if (instr_valid && instr_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    pops++;
                    last_pop_pc = instr_pc;
                    check_eq("instr_pc", 32'(instr_pc), 32'(e.pc));
                    check_eq("instr", instr, e.data);
                end
            end
        end
    end

    initial begin
        int  p0;
        bit  found;
        rst_f       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        br_take     = 1'b0;
        br_rel      = 1'b0;
        br_imm      = '0;
        mon_en      = 1'b0;
        pend_v      = 1'b0;
        in_flight   = 1'b0;
        first_chk   = 1'b0;
        pops        = 0;
        accepted    = 0;
        last_pop_pc = '0;
        nxt_addr    = RST_ADDR;

        // full throughput with ack tied high
        lat_min = 0; lat_max = 0; ready_pct = 100; br_pct = 0;
        do_reset(1'b0);
        p0 = pops;
        repeat (10) step();
        #2;
        check_eq("throughput", 32'(pops - p0), 32'd9);

        // consumer stalled: queue fills to DEPTH and fetching stops
        ready_pct = 0;
        do_reset(1'b0);
        accepted = 0;
        repeat (8) step();
        check_eq("stall_accepted", 32'(accepted), 32'(DEPTH));
        check_eq("stall_req_low", 32'(imem_req), 32'd0);
        ready_pct = 100;
        repeat (5) step();

        // slow memory
        lat_min = 3; lat_max = 3;
        repeat (20) step();

        // absolute redirect while a request is outstanding
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = new_req;
        end
        check_eq("drop_req_found", 32'(found), 32'd1);
        step(1'b1, 1'b0, 16'h0040);
        p0 = pops;
        for (int i = 0; i < 30 && pops == p0; i++) step();
        check_eq("br_abs_first_pc", 32'(last_pop_pc), 32'h0040);

        // relative redirect wrapping past the top of the address space
        lat_min = 0; lat_max = 0; ready_pct = 0;
        step(1'b1, 1'b0, 16'hFFFE);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (exp_q.size() > 0) && (exp_q[0].pc == 16'hFFFE);
        end
        check_eq("wrap_head_found", 32'(found), 32'd1);
        step(1'b1, 1'b1, 16'h0003);
        step();
        check_eq("flush_valid", 32'(instr_valid), 32'd0);
        ready_pct = 100;
        p0 = pops;
        for (int i = 0; i < 30 && pops == p0; i++) step();
        check_eq("br_rel_wrap_pc", 32'(last_pop_pc), 32'h0002);

        // reset while a request is outstanding, ack arrives right after reset
        lat_min = 5; lat_max = 5;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = new_req;
        end
        step();
        do_reset(1'b1);
        lat_min = 0; lat_max = 0;
        step();
        check_eq("rst_ack_ignored", 32'(instr_valid), 32'd0);
        repeat (10) step();

        // randomized traffic with redirects
        lat_min = 0; lat_max = 3; ready_pct = 70; br_pct = 5;
        repeat (3000) step();
        br_pct = 0; ready_pct = 100;
        repeat (20) step();
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
